// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, data-memory freeze/timeout, branch flush.
// Optional HAZ_PERF_CNT_EN builds a saturating 16-bit stall-cycle counter on stall_cnt.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_UsesRt,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_WeSel,
  input  logic        EX_Branch_Taken,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic        dmem_ready,
  output logic        PC_Write,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Bubble,
  output logic        MEMWB_Bubble,
  output logic        EXMEM_Hold,
  output logic        dmem_req,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  // state    | meaning
  // RUN      | normal flow; hazards and memory accesses decoded each cycle
  // MEM_WAIT | pipeline frozen until dmem_ready or the wait counter times out
  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic          r_mem_err, w_set_err;
  logic          w_lu, w_ma, w_eval_run;

  assign w_lu = EX_MemRead && (EX_WeSel != 5'd0) &&
                ((EX_WeSel == ID_rs) || (ID_UsesRt && (EX_WeSel == ID_rt)));
  assign w_ma = MEM_MemRead || MEM_MemWrite;

  always_comb begin
    PC_Write       = 1'b1;
    IFID_Write     = 1'b1;
    IFID_Flush     = 1'b0;
    IDEX_Bubble    = 1'b0;
    MEMWB_Bubble   = 1'b0;
    EXMEM_Hold     = 1'b0;
    dmem_req       = 1'b0;
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_set_err      = 1'b0;
    w_eval_run     = 1'b0;

    if (!rst_n) begin
      PC_Write       = 1'b0;
      IFID_Write     = 1'b0;
      IFID_Flush     = 1'b1;
      IDEX_Bubble    = 1'b1;
      MEMWB_Bubble   = 1'b1;
      w_state_nxt    = RUN;
      w_wait_cnt_nxt = '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_ma && !dmem_ready) begin
            PC_Write       = 1'b0;
            IFID_Write     = 1'b0;
            EXMEM_Hold     = 1'b1;
            MEMWB_Bubble   = 1'b1;
            dmem_req       = 1'b1;
            w_state_nxt    = MEM_WAIT;
            w_wait_cnt_nxt = '0;
          end else begin
            dmem_req   = w_ma;
            w_eval_run = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            dmem_req    = 1'b1;
            w_eval_run  = 1'b1;
            w_state_nxt = RUN;
          end else if (r_wait_cnt == CW'(MEM_TIMEOUT)) begin
            // Abandon the access: release the pipeline but keep the load result out of MEM/WB.
            w_set_err      = 1'b1;
            MEMWB_Bubble   = 1'b1;
            w_state_nxt    = RUN;
            w_wait_cnt_nxt = '0;
          end else begin
            PC_Write       = 1'b0;
            IFID_Write     = 1'b0;
            EXMEM_Hold     = 1'b1;
            MEMWB_Bubble   = 1'b1;
            dmem_req       = 1'b1;
            w_wait_cnt_nxt = r_wait_cnt + CW'(1);
          end
        end
        default: w_state_nxt = RUN;
      endcase

      if (w_eval_run) begin
        if (EX_Branch_Taken) begin
          IFID_Flush  = 1'b1;
          IDEX_Bubble = 1'b1;
          PC_Write    = 1'b1;
        end else if (w_lu) begin
          PC_Write    = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Bubble = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_mem_err  <= r_mem_err | w_set_err;
    end
  end

  assign mem_err = r_mem_err;

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!PC_Write && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected outputs are queued as each cycle is driven and
// compared at the following falling edge.
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  ID_rs = '0, ID_rt = '0, EX_WeSel = '0;
  logic        ID_UsesRt = 0, EX_MemRead = 0, EX_Branch_Taken = 0;
  logic        MEM_MemRead = 0, MEM_MemWrite = 0, dmem_ready = 0;
  logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, MEMWB_Bubble, EXMEM_Hold;
  logic        dmem_req, mem_err;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;
  int exp_sc = 0;

  typedef struct {
    logic [7:0]  outs;
    logic [15:0] sc;
    string       tag;
  } exp_t;
  exp_t sb_q[$];

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_WeSel(EX_WeSel), .EX_Branch_Taken(EX_Branch_Taken),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .dmem_ready(dmem_ready),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Bubble(IDEX_Bubble), .MEMWB_Bubble(MEMWB_Bubble), .EXMEM_Hold(EXMEM_Hold),
    .dmem_req(dmem_req), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Hold, MEMWB_Bubble, dmem_req, mem_err}
  localparam logic [7:0] O_RST    = 8'h34;
  localparam logic [7:0] O_NORM   = 8'hC0;
  localparam logic [7:0] O_NORM_E = 8'hC1;
  localparam logic [7:0] O_ACC    = 8'hC2;
  localparam logic [7:0] O_FRZ    = 8'h0E;
  localparam logic [7:0] O_LU     = 8'h10;
  localparam logic [7:0] O_BR     = 8'hF0;
  localparam logic [7:0] O_BR_ACC = 8'hF2;
  localparam logic [7:0] O_TMO    = 8'hC4;

  function automatic logic [7:0] outs_now();
    return {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Hold, MEMWB_Bubble, dmem_req, mem_err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] sc_model(input int v);
`ifdef HAZ_PERF_CNT_EN
    return (v > 65535) ? 16'hFFFF : 16'(v);
`else
    return (v < 0) ? 16'h0 : 16'h0;
`endif
  endfunction

  // One cycle of stimulus: drive just after the rising edge, queue what that cycle must show.
  task automatic step(input string tag, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic exmr, input logic [4:0] we, input logic br,
                      input logic mmr, input logic mmw, input logic rdy, input logic [7:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    ID_rs = rs; ID_rt = rt; ID_UsesRt = urt; EX_MemRead = exmr; EX_WeSel = we;
    EX_Branch_Taken = br; MEM_MemRead = mmr; MEM_MemWrite = mmw; dmem_ready = rdy;
    e.outs = exp;
    e.sc   = sc_model(exp_sc);
    e.tag  = tag;
    sb_q.push_back(e);
    if (!exp[7]) exp_sc++;
  endtask

  task automatic idle(input string tag, input logic [7:0] exp);
    step(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk(e.tag, 32'(outs_now()), 32'(e.outs));
      chk({e.tag, "_stall_cnt"}, 32'(stall_cnt), 32'(e.sc));
    end
  end

  initial begin
    #3;
    chk("reset_outs", 32'(outs_now()), 32'(O_RST));
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    #9 rst_n = 1'b1;

    idle("idle", O_NORM);
    step("lu_rs", 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, O_LU);
    step("lu_after", 5'd8, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM);
    step("lu_r0", 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM);
    step("rt_unused", 5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM);
    step("rt_used", 5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, O_LU);
    step("branch", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_BR);
    step("ready_acc", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, O_ACC);
    step("stray_ready", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_NORM);

    for (int i = 0; i < 3; i++)
      step($sformatf("slow_wait%0d", i), 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_FRZ);
    step("slow_ready", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, O_ACC);
    idle("slow_after", O_NORM);

    for (int i = 0; i < 2; i++)
      step($sformatf("simul_wait%0d", i), 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, O_FRZ);
    step("simul_ready", 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, O_BR_ACC);
    idle("simul_after", O_NORM);

    for (int i = 0; i < 5; i++)
      step($sformatf("tmo_wait%0d", i), 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_FRZ);
    step("tmo_expire", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_TMO);
    idle("tmo_err_set", O_NORM_E);
    step("tmo_err_sticky", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hC3);

    for (int i = 0; i < 2; i++)
      step($sformatf("arst_wait%0d", i), 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0F);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outs", 32'(outs_now()), 32'(O_RST));
    chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    MEM_MemRead = 1'b0;
    #1 rst_n = 1'b1;
    exp_sc = 0;
    idle("arst_run", O_NORM);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Stall/flush controller for the 5-stage MIPS pipeline. It detects load-use hazards that operand forwarding cannot cover, sequences pipeline freezes while the data memory handshake is outstanding, and flushes wrong-path instructions on a taken branch. Its outputs drive the PC write enable and the write, flush and bubble controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
- MEM_TIMEOUT, 15: maximum MEM_WAIT cycles before the access is abandoned (1..255).
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- ID_rs, ID_rt  in  5 each  source registers of the instruction in ID.
- ID_UsesRt  in  1  the ID instruction reads rt as an operand.
- EX_MemRead  in  1  the EX instruction is a load.
- EX_WeSel  in  5  destination register of the EX instruction.
- EX_Branch_Taken  in  1  branch resolved taken in EX.
- MEM_MemRead, MEM_MemWrite  in  1 each  the MEM instruction accesses data memory.
- dmem_ready  in  1  data memory completes the current access this cycle.
- PC_Write, IFID_Write  out  1 each  register update enables.
- IFID_Flush, IDEX_Bubble, MEMWB_Bubble  out  1 each  load a NOP into that register.
- EXMEM_Hold  out  1  EX/MEM keeps its contents.
- dmem_req  out  1  data memory request.
- mem_err  out  1  sticky flag: a memory access timed out.
- stall_cnt  out  16  stall-cycle counter (only with the macro below).

## Operation
- States: RUN, MEM_WAIT. Reset state is RUN. Wait counter is $clog2(MEM_TIMEOUT+1) bits.
- Load-use hazard (lu): EX_MemRead && EX_WeSel!=0 && (EX_WeSel==ID_rs || (ID_UsesRt && EX_WeSel==ID_rt)).
- Memory access (ma): MEM_MemRead || MEM_MemWrite.
- Default outputs in RUN: PC_Write=IFID_Write=1; all flush, bubble and hold outputs 0.
- Priority in RUN, highest first:
  1. ma && !dmem_ready: dmem_req=1. PC_Write=IFID_Write=0, EXMEM_Hold=1, IDEX_Bubble=0 (ID/EX holds because its write is tied to IFID_Write), MEMWB_Bubble=1. Go to MEM_WAIT and clear the wait counter.
  2. EX_Branch_Taken: IFID_Flush=1, IDEX_Bubble=1, PC_Write=1.
  3. lu: PC_Write=IFID_Write=0, IDEX_Bubble=1, for one cycle. This follows automatically, because the load leaves EX on the next cycle.
  4. If ma && dmem_ready, dmem_req=1 and the normal flow applies.
- MEM_WAIT: dmem_req=1 and the freeze outputs from rule 1 are held. Branch and load-use decisions are suppressed, because EX and ID are frozen and their inputs stay stable.
  - dmem_ready=1: outputs equal the RUN evaluation with ma satisfied (MEMWB_Bubble=0, the access completes). Next state is RUN.
  - Wait counter == MEM_TIMEOUT with no ready: set mem_err, dmem_req=0, MEMWB_Bubble=1, unfreeze. Next state is RUN and the access is dropped.
  - Otherwise the wait counter increments.
- mem_err is cleared only by reset.

## Timing
- All decode is combinational from the state and the inputs. State, wait counter, mem_err and stall_cnt are registered on the rising edge of clk.
- A ready access adds zero cycles.
- Each non-ready cycle adds one stall cycle. A timeout costs MEM_TIMEOUT+1 cycles.
- A load-use hazard costs exactly 1 cycle.
- A taken branch costs 2 wrong-path slots, flushed in the same cycle the branch resolves.
- While rst_n=0 (asynchronous, effective immediately):
  - state=RUN, wait counter=0, mem_err=0, stall_cnt=0.
  - PC_Write=IFID_Write=0, IFID_Flush=IDEX_Bubble=MEMWB_Bubble=1, EXMEM_Hold=0, dmem_req=0.
- Reset asserted during MEM_WAIT abandons the access immediately.
- dmem_ready arriving outside a memory access is ignored.

## Configuration
- HAZ_PERF_CNT_EN defined: stall_cnt increments every cycle in which rst_n=1 and PC_Write=0. It saturates at 16'hFFFF.
- HAZ_PERF_CNT_EN undefined: no counter logic is built, and stall_cnt is tied to 16'h0000.

## Test plan
- Load-use: EX_MemRead=1, EX_WeSel=8, ID_rs=8 -> exactly one cycle of PC_Write=0 and IDEX_Bubble=1, then normal flow. Repeat with EX_WeSel=0 -> no stall.
- Store data on rt: ID_rt=9, ID_UsesRt=0, EX_WeSel=9 with a load -> no stall. Same stimulus with ID_UsesRt=1 -> 1 stall.
- Slow memory: MEM_MemRead=1, dmem_ready low for 3 cycles -> 3 cycles of EXMEM_Hold=1, MEMWB_Bubble=1 and dmem_req=1. On the 4th cycle ready -> MEMWB_Bubble=0, state RUN. With the macro, stall_cnt=3.
- Simultaneous events: taken branch, a load-use hazard and a non-ready access in the same cycle -> freeze only. When ready arrives -> IFID_Flush=1 and IDEX_Bubble=1 in that cycle.
- Timeout: MEM_TIMEOUT=4, ready never asserted -> mem_err=1 after 5 wait cycles, dmem_req drops, pipeline resumes, and mem_err stays set until rst_n=0.
- Asynchronous reset mid-wait: drop rst_n between clock edges while in MEM_WAIT -> outputs take reset values immediately. After release -> RUN, stall_cnt=0.
